// File: rtl/axil_slave_mem_pkg.sv
// Shared types and helpers for the AXI4-Lite slave word memory.
package axil_slave_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] index;
  } decode_t;

  // Byte address to word index; the low two offset bits are dropped so
  // unaligned addresses land on their containing word.
  function automatic decode_t addr_decode(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input int unsigned depth);
    logic [63:0] offset;
    decode_t     d;
    offset  = addr - base;
    d.valid = (addr >= base) && (offset[63:2] < 62'(depth));
    d.index = offset[33:2];
    return d;
  endfunction

endpackage

// File: rtl/axil_slave_mem_ram.sv
// DEPTH x 32 word store: byte-enable write port, registered read port,
// whole array cleared by the asynchronous reset.
module axil_slave_mem_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             rd_en,
  input  logic             rd_ok,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write; a same-edge read of the same word sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register only loads on an accepted read, so data holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_ok ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave word memory with independent write and read paths.
// Optional counters: define AXIL_SLAVE_MEM_STATS_EN to add stat_* ports.
//
// state  | meaning
// W_IDLE | accepting AW and W independently into holding registers
// W_RESP | write committed, BVALID/BRESP held until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID/RDATA/RRESP held until RREADY
module axil_slave_mem
  import axil_slave_mem_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH        = 64,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h4000_0000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
`ifdef AXIL_SLAVE_MEM_STATS_EN
  ,
  output logic [15:0]                       stat_wr_cnt,
  output logic [15:0]                       stat_rd_cnt,
  output logic [15:0]                       stat_err_cnt
`endif
);

  localparam int unsigned IDX_W = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                            aw_held, aw_held_nxt, w_held, w_held_nxt;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;
  logic                            awready_q, awready_nxt, wready_q, wready_nxt;
  logic                            bvalid_q, bvalid_nxt;
  logic [1:0]                      bresp_q, bresp_nxt;
  logic                            arready_q, arready_nxt, rvalid_q, rvalid_nxt;
  logic [1:0]                      rresp_q, rresp_nxt;
  logic                            mem_we, rd_en;
  logic                            aw_hs, w_hs, ar_hs;
  decode_t                         wr_dec, rd_dec;
  logic                            unused_bits;

  assign aw_hs  = awready_q & S_AXI_AWVALID;
  assign w_hs   = wready_q  & S_AXI_WVALID;
  assign ar_hs  = arready_q & S_AXI_ARVALID;
  assign wr_dec = addr_decode(64'(aw_addr_q), 64'(C_BASE_ADDR), C_MEM_DEPTH);
  assign rd_dec = addr_decode(64'(S_AXI_ARADDR), 64'(C_BASE_ADDR), C_MEM_DEPTH);

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_dec.index, rd_dec.index};

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;

  // Write path next state: collect AW/W in any order, commit one cycle after both are held.
  always_comb begin
    wr_state_nxt = wr_state;
    aw_held_nxt  = aw_held;
    w_held_nxt   = w_held;
    awready_nxt  = 1'b0;
    wready_nxt   = 1'b0;
    bvalid_nxt   = bvalid_q;
    bresp_nxt    = bresp_q;
    mem_we       = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (aw_held && w_held) begin
          mem_we       = wr_dec.valid;
          bvalid_nxt   = 1'b1;
          bresp_nxt    = wr_dec.valid ? RESP_OKAY : RESP_SLVERR;
          aw_held_nxt  = 1'b0;
          w_held_nxt   = 1'b0;
          wr_state_nxt = W_RESP;
        end else begin
          aw_held_nxt = aw_held | aw_hs;
          w_held_nxt  = w_held | w_hs;
          awready_nxt = !aw_held_nxt;
          wready_nxt  = !w_held_nxt;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_nxt   = 1'b0;
          awready_nxt  = 1'b1;
          wready_nxt   = 1'b1;
          wr_state_nxt = W_IDLE;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Write path registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state  <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wr_state  <= wr_state_nxt;
      aw_held   <= aw_held_nxt;
      w_held    <= w_held_nxt;
      awready_q <= awready_nxt;
      wready_q  <= wready_nxt;
      bvalid_q  <= bvalid_nxt;
      bresp_q   <= bresp_nxt;
    end
  end

  // AW/W holding registers load on their own handshakes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Read path next state: sample on AR handshake, hold response until RREADY.
  always_comb begin
    rd_state_nxt = rd_state;
    arready_nxt  = 1'b0;
    rvalid_nxt   = rvalid_q;
    rresp_nxt    = rresp_q;
    rd_en        = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arready_nxt = 1'b1;
        if (ar_hs) begin
          rd_en        = 1'b1;
          rvalid_nxt   = 1'b1;
          rresp_nxt    = rd_dec.valid ? RESP_OKAY : RESP_SLVERR;
          arready_nxt  = 1'b0;
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_nxt   = 1'b0;
          arready_nxt  = 1'b1;
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Read path registers.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rd_state  <= rd_state_nxt;
      arready_q <= arready_nxt;
      rvalid_q  <= rvalid_nxt;
      rresp_q   <= rresp_nxt;
    end
  end

  axil_slave_mem_ram #(
    .DEPTH (C_MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .we     (mem_we),
    .wr_idx (wr_dec.index[IDX_W-1:0]),
    .wdata  (w_data_q),
    .wstrb  (w_strb_q),
    .rd_en  (rd_en),
    .rd_ok  (rd_dec.valid),
    .rd_idx (rd_dec.index[IDX_W-1:0]),
    .rdata  (S_AXI_RDATA)
  );

`ifdef AXIL_SLAVE_MEM_STATS_EN
  logic        b_hs, r_hs;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign b_hs    = bvalid_q & S_AXI_BREADY;
  assign r_hs    = rvalid_q & S_AXI_RREADY;
  assign err_inc = {1'b0, b_hs && (bresp_q == RESP_SLVERR)}
                 + {1'b0, r_hs && (rresp_q == RESP_SLVERR)};
  assign err_sum = {1'b0, stat_err_cnt} + 17'(err_inc);

  // Saturating completion and error counters.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (b_hs && stat_wr_cnt != 16'hFFFF) stat_wr_cnt <= stat_wr_cnt + 16'd1;
      if (r_hs && stat_rd_cnt != 16'hFFFF) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      stat_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_axil_slave_mem.sv
// Directed self-checking bench for axil_slave_mem (depth 64, base 0x4000_0000).
module tb_axil_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
`ifdef AXIL_SLAVE_MEM_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_slave_mem dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
`ifdef AXIL_SLAVE_MEM_STATS_EN
    ,
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_err_cnt  (stat_err_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp, output bit to);
    int n = 0;
    bit aw_go, w_go;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; to = 1'b0; resp = 2'b11;
    while ((awvalid || wvalid) && n < 20) begin
      aw_go = awready && awvalid;
      w_go  = wready && wvalid;
      step();
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid = 1'b0;
      n++;
    end
    while (!bvalid && n < 40) begin step(); n++; end
    if (!bvalid) begin
      to = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    resp = bresp;
    bready = 1'b1; step(); bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit to);
    int n = 0;
    bit go;
    araddr = addr; arvalid = 1'b1; to = 1'b0; data = 'x; resp = 2'b11;
    while (arvalid && n < 20) begin
      go = arready;
      step();
      if (go) arvalid = 1'b0;
      n++;
    end
    while (!rvalid && n < 40) begin step(); n++; end
    if (!rvalid) begin
      to = 1'b1; arvalid = 1'b0;
      return;
    end
    data = rdata; resp = rresp;
    rready = 1'b1; step(); rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake got %b exp 00000", {awready, wready, bvalid, arready, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_resp_data got bresp %b rresp %b rdata %h exp 0", bresp, rresp, rdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      errors++; $display("FAIL reset_release_ready got %b exp 11100", {awready, wready, arready, bvalid, rvalid});
    end
  endtask

  task automatic test_aligned();
    awaddr = 32'h4000_0010; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      errors++; $display("FAIL aligned_after_hs got %b exp 000", {awready, wready, bvalid});
    end
    step();
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      errors++; $display("FAIL aligned_bresp got bvalid %b bresp %b exp 1 00", bvalid, bresp);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      errors++; $display("FAIL aligned_b_done got %b exp 011", {bvalid, awready, wready});
    end
    araddr = 32'h4000_0010; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    checks++;
    if ({rvalid, arready, rresp} !== 4'b1000 || rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL aligned_read got rvalid %b arready %b rresp %b rdata %h exp 1 0 00 deadbeef", rvalid, arready, rresp, rdata);
    end
    step();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL aligned_read_hold got rvalid %b rdata %h exp 1 deadbeef", rvalid, rdata);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++; $display("FAIL aligned_r_done got %b exp 01", {rvalid, arready});
    end
  endtask

  task automatic test_channel_order();
    logic [31:0] d; logic [1:0] r; bit to;
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({wready, bvalid} !== 2'b00) begin
        errors++; $display("FAIL order_w_held cycle %0d got wready %b bvalid %b exp 0 0", i, wready, bvalid);
      end
      if (i < 2) step();
    end
    awaddr = 32'h4000_0004; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++; $display("FAIL order_bvalid_early got %b exp 0", bvalid);
    end
    step();
    checks++;
    if ({bvalid, bresp} !== 3'b100) begin
      errors++; $display("FAIL order_bresp got bvalid %b bresp %b exp 1 00", bvalid, bresp);
    end
    bready = 1'b1; step(); bready = 1'b0;
    do_read(32'h4000_0004, d, r, to);
    checks++;
    if (to || d !== 32'h1234_5678 || r !== 2'b00) begin
      errors++; $display("FAIL order_readback got %h resp %b timeout %0b exp 12345678 00", d, r, to);
    end
  endtask

  task automatic test_strobes();
    logic [31:0] d; logic [1:0] r, r1, r2, r3; bit to1, to2, to3, to;
    do_write(32'h4000_0008, 32'hFFFF_FFFF, 4'hF, r1, to1);
    do_write(32'h4000_0008, 32'h0000_0000, 4'b0101, r2, to2);
    checks++;
    if (to1 || to2 || r1 !== 2'b00 || r2 !== 2'b00) begin
      errors++; $display("FAIL strobe_bresp got %b %b timeout %0b%0b exp 00 00", r1, r2, to1, to2);
    end
    do_read(32'h4000_0008, d, r, to);
    checks++;
    if (to || d !== 32'hFF00_FF00) begin
      errors++; $display("FAIL strobe_readback got %h timeout %0b exp ff00ff00", d, to);
    end
    do_write(32'h4000_0008, 32'h1234_5678, 4'h0, r3, to3);
    do_read(32'h4000_0008, d, r, to);
    checks++;
    if (to || to3 || r3 !== 2'b00 || d !== 32'hFF00_FF00) begin
      errors++; $display("FAIL strobe_zero got %h bresp %b exp ff00ff00 00", d, r3);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; bit to;
    do_write(32'h4000_0100, 32'hCAFE_F00D, 4'hF, r, to);
    checks++;
    if (to || r !== 2'b10) begin
      errors++; $display("FAIL oor_write_bresp got %b timeout %0b exp 10", r, to);
    end
    do_read(32'h4000_0000, d, r, to);
    checks++;
    if (to || d !== 32'h0 || r !== 2'b00) begin
      errors++; $display("FAIL oor_word0_unchanged got %h resp %b exp 00000000 00", d, r);
    end
    do_read(32'h4000_0010, d, r, to);
    do_read(32'h3FFF_FFFC, d, r, to);
    checks++;
    if (to || d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL oor_read_low got %h resp %b exp 00000000 10", d, r);
    end
    do_write(32'h4000_00FC, 32'hA5A5_5A5A, 4'hF, r, to);
    checks++;
    if (to || r !== 2'b00) begin
      errors++; $display("FAIL last_word_bresp got %b exp 00", r);
    end
    do_read(32'h4000_00FE, d, r, to);
    checks++;
    if (to || d !== 32'hA5A5_5A5A || r !== 2'b00) begin
      errors++; $display("FAIL last_word_unaligned got %h resp %b exp a5a55a5a 00", d, r);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; bit to;
    do_write(32'h4000_0020, 32'h1111_1111, 4'hF, r, to);
    awaddr = 32'h4000_0020; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h4000_0020; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    checks++;
    if ({bvalid, rvalid} !== 2'b11 || rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL collision_old_data got bvalid %b rvalid %b rdata %h exp 1 1 11111111", bvalid, rvalid, rdata);
    end
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    do_read(32'h4000_0020, d, r, to);
    checks++;
    if (to || d !== 32'h2222_2222) begin
      errors++; $display("FAIL collision_new_data got %h exp 22222222", d);
    end
  endtask

  task automatic test_backpressure();
    awaddr = 32'h4000_0100; wdata = 32'h5555_5555; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    awaddr = 32'h4000_0030;
    step();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bvalid, bresp, awready, wready} !== 5'b11000) begin
        errors++; $display("FAIL bp_hold cycle %0d got bvalid %b bresp %b awready %b wready %b exp 1 10 0 0", i, bvalid, bresp, awready, wready);
      end
      step();
    end
    awvalid = 1'b0;
    bready = 1'b1; step(); bready = 1'b0;
    checks++;
    if ({bvalid, awready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got bvalid %b awready %b exp 0 1", bvalid, awready);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d; logic [1:0] r; bit to;
    wdata = 32'h7777_7777; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    araddr = 32'h4000_0010; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || wready !== 1'b0) begin
      errors++; $display("FAIL midrst_setup got rvalid %b wready %b exp 1 0", rvalid, wready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid, arready, wready} !== 3'b000 || rdata !== 32'h0) begin
      errors++; $display("FAIL midrst_async got rvalid %b arready %b wready %b rdata %h exp 0 0 0 0", rvalid, arready, wready, rdata);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL midrst_discard got %b exp 111", {awready, wready, arready});
    end
    do_read(32'h4000_0010, d, r, to);
    checks++;
    if (to || d !== 32'h0) begin
      errors++; $display("FAIL midrst_mem_0010 got %h exp 00000000", d);
    end
    do_read(32'h4000_0004, d, r, to);
    checks++;
    if (to || d !== 32'h0) begin
      errors++; $display("FAIL midrst_mem_0004 got %h exp 00000000", d);
    end
  endtask

`ifdef AXIL_SLAVE_MEM_STATS_EN
  task automatic test_stats();
    logic [31:0] d; logic [1:0] r; bit to;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    do_write(32'h4000_0000, 32'h1, 4'hF, r, to);
    do_read(32'h4000_0000, d, r, to);
    do_write(32'h5000_0000, 32'h2, 4'hF, r, to);
    do_read(32'h3000_0000, d, r, to);
    do_read(32'h4000_0004, d, r, to);
    checks++;
    if (stat_wr_cnt !== 16'd2 || stat_rd_cnt !== 16'd3 || stat_err_cnt !== 16'd2) begin
      errors++; $display("FAIL stats got wr %0d rd %0d err %0d exp 2 3 2", stat_wr_cnt, stat_rd_cnt, stat_err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_aligned();
    test_channel_order();
    test_strobes();
    test_out_of_range();
    test_collision();
    test_backpressure();
    test_reset_midflight();
`ifdef AXIL_SLAVE_MEM_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
